// File: rtl/br_pkg.sv
// Shared branch-mask definitions used by the allocator, the branch unit and the issue queues.
package br_pkg;

  localparam int WIDTH_BRM = 4;
  localparam int NUM_BR    = 2 ** WIDTH_BRM;

  typedef logic [NUM_BR-1:0] brmask_t;

endpackage

// File: rtl/br_kill_gen.sv
// Combinational kill-mask generator: squashes every busy tag younger than the resolved one,
// with age measured as the offset from the current head of the circular window.
module br_kill_gen #(
  parameter  int WIDTH_BRM = br_pkg::WIDTH_BRM,
  localparam int NUM_BR    = 2 ** WIDTH_BRM
) (
  input  logic [WIDTH_BRM-1:0] head,
  input  logic [NUM_BR-1:0]    busy,
  input  logic [WIDTH_BRM-1:0] res_tag,
  output logic [NUM_BR-1:0]    kill_mask,
  output logic [WIDTH_BRM-1:0] res_off
);

  // Modular subtraction gives the age offset directly, so wrap-around needs no special case.
  assign res_off = res_tag - head;

  generate
    for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_tag
      logic [WIDTH_BRM-1:0] tag_off;
      assign tag_off       = WIDTH_BRM'(gi) - head;
      assign kill_mask[gi] = busy[gi] && (tag_off > res_off);
    end
  endgenerate

endmodule

// File: rtl/br_alloc.sv
// Branch-tag allocator: hands out tags from a circular window, retires resolved tags in order
// and squashes younger tags on a mispredict, broadcasting the registered kill mask.
module br_alloc #(
  parameter  int WIDTH_BRM = br_pkg::WIDTH_BRM,
  localparam int NUM_BR    = 2 ** WIDTH_BRM
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc_req,
  output logic                 o_alloc_ready,
  output logic [WIDTH_BRM-1:0] o_alloc_tag,
  output logic [NUM_BR-1:0]    o_brmask,
  input  logic                 i_res_valid,
  input  logic [WIDTH_BRM-1:0] i_res_tag,
  input  logic                 i_res_mispredict,
  output logic                 o_kill_valid,
  output logic [NUM_BR-1:0]    o_kill_mask,
  output logic                 o_empty
);

  localparam logic [WIDTH_BRM:0]   CNT_ONE  = 1;
  localparam logic [WIDTH_BRM:0]   CNT_FULL = NUM_BR;
  localparam logic [WIDTH_BRM-1:0] HEAD_ONE = 1;

  logic [WIDTH_BRM-1:0] head_reg, head_next;
  logic [WIDTH_BRM:0]   count_reg, count_next;
  logic [NUM_BR-1:0]    busy_reg, busy_next;
  logic [NUM_BR-1:0]    done_reg, done_next;
  logic                 kill_valid_reg;
  logic [NUM_BR-1:0]    kill_mask_reg;

  logic [WIDTH_BRM-1:0] tail;
  logic [NUM_BR-1:0]    kill_mask;
  logic [WIDTH_BRM-1:0] res_off;
  logic                 mispredict_req;
  logic                 grant;
  logic                 res_accept;
  logic                 kill_fire;
  logic                 retire;

  br_kill_gen #(.WIDTH_BRM(WIDTH_BRM)) u_kill_gen (
    .head      (head_reg),
    .busy      (busy_reg),
    .res_tag   (i_res_tag),
    .kill_mask (kill_mask),
    .res_off   (res_off)
  );

  assign tail           = head_reg + count_reg[WIDTH_BRM-1:0];
  // A presented mispredict blocks allocation even if the tag turns out not to be busy.
  assign mispredict_req = i_res_valid && i_res_mispredict;
  assign o_alloc_ready  = (count_reg != CNT_FULL) && !mispredict_req;
  assign o_alloc_tag    = tail;

  assign grant      = i_alloc_req && o_alloc_ready;
  assign res_accept = i_res_valid && busy_reg[i_res_tag];
  assign kill_fire  = res_accept && i_res_mispredict;
  assign retire     = busy_reg[head_reg] && done_reg[head_reg];

  always_comb begin
    head_next  = head_reg;
    count_next = count_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;

    if (grant) begin
      busy_next[tail] = 1'b1;
      done_next[tail] = 1'b0;
      count_next      = count_reg + CNT_ONE;
    end

    if (res_accept) begin
      done_next[i_res_tag] = 1'b1;
      if (kill_fire) begin
        busy_next  = busy_next & ~kill_mask;
        count_next = {1'b0, res_off} + CNT_ONE;
      end
    end

    // The head is never in the kill set, so retiring it composes cleanly with a mispredict.
    if (retire) begin
      busy_next[head_reg] = 1'b0;
      head_next           = head_reg + HEAD_ONE;
      count_next          = count_next - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_reg       <= '0;
      count_reg      <= '0;
      busy_reg       <= '0;
      done_reg       <= '0;
      kill_valid_reg <= 1'b0;
      kill_mask_reg  <= '0;
    end else begin
      head_reg       <= head_next;
      count_reg      <= count_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      kill_valid_reg <= kill_fire;
      kill_mask_reg  <= kill_fire ? kill_mask : '0;
    end
  end

  assign o_brmask     = busy_reg;
  assign o_empty      = (count_reg == '0);
  assign o_kill_valid = kill_valid_reg;
  assign o_kill_mask  = kill_mask_reg;

endmodule
